// File: rtl/io_pkg.sv
// Shared constants for the I/O peripheral: register offsets, control/status
// bit positions and default parameter values.
package io_pkg;

   localparam int unsigned DEF_PRESCALE   = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   localparam logic [3:0] REG_GPIO_OUT = 4'h0;
   localparam logic [3:0] REG_GPIO_IN  = 4'h1;
   localparam logic [3:0] REG_TMR_LOAD = 4'h2;
   localparam logic [3:0] REG_TMR_CTRL = 4'h3;
   localparam logic [3:0] REG_TMR_STAT = 4'h4;
   localparam logic [3:0] REG_TX_DATA  = 4'h5;
   localparam logic [3:0] REG_TX_STAT  = 4'h6;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;
   localparam int unsigned CTRL_AUTO   = 2;

   localparam int unsigned STAT_EXPIRED = 0;

   localparam int unsigned TXS_FULL    = 0;
   localparam int unsigned TXS_EMPTY   = 1;
   localparam int unsigned TXS_CNT_LSB = 2;
   localparam int unsigned TXS_OVF     = 7;

endpackage

// File: rtl/io_tx_fifo.sv
// Transmit FIFO: power-of-two depth (1..8), sticky overflow flag, head byte
// forced to zero while empty.
module io_tx_fifo
   import io_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   input  logic       ovf_clr_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [3:0] count_o,
   output logic       ovf_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam logic [3:0]    DEPTH_C = 4'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          full, empty, push_ok, pop_ok;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign full    = (cnt_q == DEPTH_C);
   assign empty   = (cnt_q == 4'd0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign push_ok = push_i & (~full | pop_i);
   assign pop_ok  = pop_i & ~empty;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok) wr_d = ptr_next(wr_q);
      if (pop_ok)  rd_d = ptr_next(rd_q);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 4'd1;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - 4'd1;
      ovf_d = (push_i & full & ~pop_i) | (ovf_q & ~ovf_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = empty ? '0 : mem_q[rd_q];
   assign full_o  = full;
   assign empty_o = empty;
   assign count_o = cnt_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/io_peripheral.sv
// Memory-mapped I/O block: GPIO with input synchronizer, prescaled 8-bit
// down-timer with interrupt, and a transmit FIFO.
module io_peripheral
   import io_pkg::*;
#(
   parameter int unsigned PRESCALE   = DEF_PRESCALE,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_cs,
   input  logic [15:0] mem_addr,
   input  logic [7:0]  mem_data_out,
   input  logic        mem_oe,
   input  logic        mem_we,
   output logic [7:0]  io_rdata,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

   logic [7:0] gpio_out_q, gpio_out_d;
   logic [7:0] sync1_q, sync2_q;
   logic [7:0] load_q, load_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] presc_q, presc_d;
   logic       pend_q, pend_d;
   logic       expired_q, expired_d;

   logic       wr, tick, expire, pop, stat_clr, ovf_clr, push;
   logic [3:0] offs;
   logic [7:0] rdata, tx_stat, fifo_head;
   logic       fifo_full, fifo_empty, fifo_ovf;
   logic [3:0] fifo_cnt;
   logic       unused_addr_hi;

   assign unused_addr_hi = ^mem_addr[15:4];
   assign offs     = mem_addr[3:0];
   assign wr       = io_cs & mem_we;
   assign push     = wr & (offs == REG_TX_DATA);
   assign stat_clr = wr & (offs == REG_TMR_STAT) & mem_data_out[STAT_EXPIRED];
   assign ovf_clr  = wr & (offs == REG_TX_STAT) & mem_data_out[TXS_OVF];
   assign tick     = ctrl_q[CTRL_EN] & (presc_q == PRESC_MAX);

   always_comb begin
      gpio_out_d = gpio_out_q;
      load_d     = load_q;
      ctrl_d     = ctrl_q;
      cnt_d      = cnt_q;
      presc_d    = presc_q;
      pend_d     = pend_q;
      expire     = 1'b0;
      if (ctrl_q[CTRL_EN]) presc_d = tick ? '0 : presc_q + 8'd1;
      // After an auto-reload expiry the counter sits at 0 for one tick period,
      // and the following tick reloads it instead of expiring again.
      if (tick) begin
         if (pend_q) begin
            cnt_d  = load_q;
            pend_d = 1'b0;
         end else if (cnt_q <= 8'd1) begin
            cnt_d  = '0;
            expire = 1'b1;
            if (ctrl_q[CTRL_AUTO]) pend_d = 1'b1;
            else                   ctrl_d[CTRL_EN] = 1'b0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
      if (wr) begin
         case (offs)
            REG_GPIO_OUT: gpio_out_d = mem_data_out;
            REG_TMR_LOAD: begin
               load_d  = mem_data_out;
               cnt_d   = mem_data_out;
               presc_d = '0;
               pend_d  = 1'b0;
            end
            REG_TMR_CTRL: ctrl_d = mem_data_out[2:0];
            default: ;
         endcase
      end
      expired_d = expire | (expired_q & ~stat_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         load_q     <= '0;
         ctrl_q     <= '0;
         cnt_q      <= '0;
         presc_q    <= '0;
         pend_q     <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         load_q     <= load_d;
         ctrl_q     <= ctrl_d;
         cnt_q      <= cnt_d;
         presc_q    <= presc_d;
         pend_q     <= pend_d;
         expired_q  <= expired_d;
      end
   end

   assign pop = tx_valid & tx_ready;

   io_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .push_i      (push),
      .push_data_i (mem_data_out),
      .pop_i       (pop),
      .ovf_clr_i   (ovf_clr),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_cnt),
      .ovf_o       (fifo_ovf)
   );

   always_comb begin
      tx_stat                      = '0;
      tx_stat[TXS_FULL]            = fifo_full;
      tx_stat[TXS_EMPTY]           = fifo_empty;
      tx_stat[TXS_CNT_LSB +: 4]    = fifo_cnt;
      tx_stat[TXS_OVF]             = fifo_ovf;
      rdata = '0;
      if (io_cs && mem_oe) begin
         case (offs)
            REG_GPIO_OUT: rdata = gpio_out_q;
            REG_GPIO_IN:  rdata = sync2_q;
            REG_TMR_LOAD: rdata = load_q;
            REG_TMR_CTRL: rdata = {5'b0, ctrl_q};
            REG_TMR_STAT: rdata = {7'b0, expired_q};
            REG_TX_DATA:  rdata = {4'b0, fifo_cnt};
            REG_TX_STAT:  rdata = tx_stat;
            default:      rdata = '0;
         endcase
      end
   end

   // Outputs are masked while reset is held so no handshake can complete then.
   assign io_rdata = rdata;
   assign gpio_out = gpio_out_q;
   assign tx_valid = rst_n & ~fifo_empty;
   assign tx_data  = rst_n ? fifo_head : '0;
   assign irq      = rst_n & expired_q & ctrl_q[CTRL_IRQ_EN];

endmodule
